// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the packet-level ALU engine:
//   HEADER_BYTES  - bytes of framing ahead of the payload (opcode, reserved,
//                   LEN low, LEN high); LEN counts these bytes too.
//   opcode_e      - recognised request opcodes.
//   state_e       - packet parser states.
//   opcode_known  - true for any opcode the engine services.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int HEADER_BYTES = 4;

   typedef enum logic [7:0] {
      OP_ECHO = 8'hEC,
      OP_ADD  = 8'hAD,
      OP_XOR  = 8'hE0,
      OP_MAX  = 8'hAA
   } opcode_e;

   typedef enum logic [2:0] {
      S_OPCODE,
      S_RSVD,
      S_LEN_LO,
      S_LEN_HI,
      S_PAYLOAD,
      S_DRAIN,
      S_RESULT
   } state_e;

   function automatic logic opcode_known(input logic [7:0] op);
      return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_XOR) || (op == OP_MAX);
   endfunction

endpackage

// File: rtl/alu_operand_assembler.sv
// ---------------------------------------------------------------------------
// alu_operand_assembler
// Collects payload bytes LSB-first into OPERAND_BYTES-wide operands.
//   clk_i, rst_i      clock, asynchronous active-high reset
//   clear_i           drop any partially assembled operand
//   byte_i            incoming payload byte
//   byte_valid_i      byte_i is consumed this cycle
//   operand_o         assembled operand (valid with operand_valid_o)
//   operand_valid_o   high in the cycle the completing byte is consumed
// The completing byte is merged combinationally so the caller can fold the
// operand into its accumulator in the same cycle the last byte arrives.
// ---------------------------------------------------------------------------
module alu_operand_assembler #(
   parameter int OPERAND_BYTES = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic [7:0]                   byte_i,
   input  logic                         byte_valid_i,
   output logic [8*OPERAND_BYTES-1:0]   operand_o,
   output logic                         operand_valid_o
);

   localparam int W = 8 * OPERAND_BYTES;

   generate
      if (OPERAND_BYTES == 1) begin : g_single
         // Every byte is a complete operand; nothing to hold.
         assign operand_o       = byte_i;
         assign operand_valid_o = byte_valid_i;
      end else begin : g_multi
         // held keeps the OPERAND_BYTES-1 most recent bytes, newest at the top,
         // so the completing byte simply lands above them.
         logic [W-9:0] held;
         logic [3:0]   cnt;
         logic         done;

         assign done            = (cnt == 4'(OPERAND_BYTES - 1));
         assign operand_o       = {byte_i, held};
         assign operand_valid_o = byte_valid_i & done;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               held <= '0;
               cnt  <= '0;
            end else if (clear_i) begin
               held <= '0;
               cnt  <= '0;
            end else if (byte_valid_i) begin
               held <= operand_o[W-1:8];
               cnt  <= done ? 4'd0 : cnt + 4'd1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/alu_packet_engine.sv
// ---------------------------------------------------------------------------
// alu_packet_engine
// Parses request packets {opcode, reserved, LEN lo, LEN hi, payload} from a
// byte stream and either echoes the payload or reduces it (ADD / XOR /
// unsigned MAX) into an OPERAND_BYTES-wide result sent back LSB first.
//   clk_i, rst_i               clock, asynchronous active-high reset
//   in_data_i/in_valid_i       request byte stream
//   in_ready_o                 byte accepted when in_valid_i & in_ready_o
//   out_data_o/out_valid_o     response byte stream, held until accepted
//   out_ready_i                downstream accepts the response byte
//   busy_o                     packet in progress or response byte pending
//   err_o                      one-cycle pulse when an unknown opcode's
//                              header completes
// ---------------------------------------------------------------------------
module alu_packet_engine
   import alu_pkg::*;
#(
   parameter int OPERAND_BYTES = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] in_data_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   output logic [7:0] out_data_o,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic       busy_o,
   output logic       err_o
);

   localparam int W = 8 * OPERAND_BYTES;

   state_e         state, state_nx;
   logic [7:0]     opcode;
   logic [7:0]     len_lo;
   logic [15:0]    count;
   logic [W-1:0]   acc;
   logic [3:0]     res_left;

   logic           in_fire;
   logic           out_free;
   logic           is_echo;
   logic           last_byte;
   logic [15:0]    len_full;
   logic [15:0]    payload_len;
   logic           enter_result;
   logic [W-1:0]   acc_nx;
   logic [W-1:0]   result_val;
   logic [W-1:0]   operand;
   logic           operand_valid;

   function automatic logic [W-1:0] combine(input logic [7:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_XOR:  return a ^ b;
         OP_MAX:  return (b > a) ? b : a;
         default: return a;
      endcase
   endfunction

   assign out_free    = !out_valid_o | out_ready_i;
   assign is_echo     = (opcode == OP_ECHO);
   assign last_byte   = (count == 16'd1);
   assign len_full    = {in_data_i, len_lo};
   assign payload_len = (len_full > 16'(HEADER_BYTES)) ? len_full - 16'(HEADER_BYTES) : 16'd0;
   assign acc_nx      = operand_valid ? combine(opcode, acc, operand) : acc;

   // A zero-length reduction finishes straight from LEN_HI with a zero result.
   assign enter_result = in_fire & !is_echo & opcode_known(opcode) &
                         (((state == S_LEN_HI) && (payload_len == 16'd0)) ||
                          ((state == S_PAYLOAD) && last_byte));
   assign result_val   = (state == S_LEN_HI) ? '0 : acc_nx;

   assign busy_o = (state != S_OPCODE) | out_valid_o;
   assign err_o  = in_fire & (state == S_LEN_HI) & !opcode_known(opcode);

   alu_operand_assembler #(
      .OPERAND_BYTES (OPERAND_BYTES)
   ) u_asm (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .clear_i         (in_fire & (state == S_LEN_HI)),
      .byte_i          (in_data_i),
      .byte_valid_i    (in_fire & (state == S_PAYLOAD) & !is_echo),
      .operand_o       (operand),
      .operand_valid_o (operand_valid)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_OPCODE;
      else       state <= state_nx;
   end

   always_comb begin
      in_ready_o = 1'b1;
      state_nx   = state;
      case (state)
         S_PAYLOAD: if (is_echo) in_ready_o = out_free;
         S_RESULT:  in_ready_o = 1'b0;
         default:   ;
      endcase
      in_fire = in_valid_i & in_ready_o;

      case (state)
         S_OPCODE: if (in_fire) state_nx = S_RSVD;
         S_RSVD:   if (in_fire) state_nx = S_LEN_LO;
         S_LEN_LO: if (in_fire) state_nx = S_LEN_HI;
         S_LEN_HI: begin
            if (in_fire) begin
               if (!opcode_known(opcode))
                  state_nx = (payload_len == 16'd0) ? S_OPCODE : S_DRAIN;
               else if (is_echo)
                  state_nx = (payload_len == 16'd0) ? S_OPCODE : S_PAYLOAD;
               else
                  state_nx = (payload_len == 16'd0) ? S_RESULT : S_PAYLOAD;
            end
         end
         S_PAYLOAD: if (in_fire && last_byte) state_nx = is_echo ? S_OPCODE : S_RESULT;
         S_DRAIN:   if (in_fire && last_byte) state_nx = S_OPCODE;
         S_RESULT:  if ((res_left == 4'd0) && out_free) state_nx = S_OPCODE;
         default:   state_nx = S_OPCODE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         opcode      <= '0;
         len_lo      <= '0;
         count       <= '0;
         acc         <= '0;
         res_left    <= '0;
         out_data_o  <= '0;
         out_valid_o <= 1'b0;
      end else begin
         // Later assignments below override this when a new byte is loaded
         // in the same cycle the pending one leaves.
         if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;

         if (in_fire && (state == S_OPCODE)) opcode <= in_data_i;
         if (in_fire && (state == S_LEN_LO)) len_lo <= in_data_i;
         if (in_fire && (state == S_LEN_HI)) begin
            count <= payload_len;
            acc   <= '0;
         end
         if (in_fire && ((state == S_PAYLOAD) || (state == S_DRAIN))) count <= count - 16'd1;

         if (in_fire && (state == S_PAYLOAD)) begin
            if (is_echo) begin
               out_data_o  <= in_data_i;
               out_valid_o <= 1'b1;
            end else begin
               acc <= acc_nx;
            end
         end

         // The first result byte goes out immediately unless an echo byte
         // from the previous packet is still waiting downstream.
         if (enter_result) begin
            if (out_free) begin
               out_data_o  <= result_val[7:0];
               out_valid_o <= 1'b1;
               acc         <= result_val >> 8;
               res_left    <= 4'(OPERAND_BYTES - 1);
            end else begin
               acc         <= result_val;
               res_left    <= 4'(OPERAND_BYTES);
            end
         end

         if ((state == S_RESULT) && out_free && (res_left != 4'd0)) begin
            out_data_o  <= acc[7:0];
            out_valid_o <= 1'b1;
            acc         <= acc >> 8;
            res_left    <= res_left - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_packet_engine.sv
module tb_alu_packet_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       busy;
   logic       err;

   logic [7:0] in_data2;
   logic       in_valid2;
   logic       in_ready2;
   logic [7:0] out_data2;
   logic       out_valid2;
   logic       out_ready2 = 1'b1;
   logic       busy2;
   logic       err2;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int err_cnt     = 0;
   int bp_viol     = 0;
   bit bp_mode     = 1'b0;
   bit rand_ready  = 1'b0;

   logic [7:0] got_q[$];
   logic [7:0] got2_q[$];
   int         out_cyc[$];
   int         acc_cyc[$];
   logic [7:0] pkt[$];
   logic [31:0] ops[$];

   always #5 clk = ~clk;

   alu_packet_engine #(.OPERAND_BYTES(4)) dut (
      .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .out_data_o(out_data), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .busy_o(busy), .err_o(err)
   );

   alu_packet_engine #(.OPERAND_BYTES(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .in_data_i(in_data2), .in_valid_i(in_valid2),
      .in_ready_o(in_ready2), .out_data_o(out_data2), .out_valid_o(out_valid2),
      .out_ready_i(out_ready2), .busy_o(busy2), .err_o(err2)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            out_cyc.push_back(cyc);
         end
         if (out_valid2 && out_ready2) got2_q.push_back(out_data2);
         if (err) err_cnt <= err_cnt + 1;
         if (bp_mode && in_valid && in_ready && out_valid && !out_ready) bp_viol <= bp_viol + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte is taken.
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      in_data  = b;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            acc_cyc.push_back(cyc);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         t++;
         if (t > 500) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            break;
         end
      end
   endtask

   task automatic send_pkt(input logic [7:0] p[$]);
      foreach (p[i]) send_byte(p[i]);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int n, input string tag);
      int t = 0;
      while (got_q.size() < n && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_count"}, 64'(got_q.size()), 64'(n));
   endtask

   function automatic logic [7:0] take();
      if (got_q.size() == 0) return 8'hxx;
      return got_q.pop_front();
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] v[$]);
      logic [31:0] s = 32'd0;
      foreach (v[i]) s = s + v[i];
      return s;
   endfunction

   task automatic run_reduce(input logic [7:0] op, input logic [31:0] v[$], input int trail,
                             input int short_len, input logic [31:0] exp_res, input string tag);
      logic [15:0] len;
      len = (short_len >= 0) ? 16'(short_len) : 16'(4 + 4 * v.size() + trail);
      pkt.delete();
      pkt.push_back(op);
      pkt.push_back(8'($urandom_range(0, 255)));
      pkt.push_back(len[7:0]);
      pkt.push_back(len[15:8]);
      if (short_len < 0) begin
         foreach (v[i]) for (int b = 0; b < 4; b++) pkt.push_back(v[i][8*b +: 8]);
         for (int k = 0; k < trail; k++) pkt.push_back(8'($urandom_range(0, 255)));
      end
      send_pkt(pkt);
      wait_out(4, tag);
      for (int i = 0; i < 4; i++) check(tag, 64'(take()), 64'(exp_res[8*i +: 8]));
   endtask

   initial begin
      int base;
      logic [7:0] eb[$];
      int t;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_valid2 = 1'b0; in_data2 = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'h00);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset in the middle of an ADD packet
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22};
      send_pkt(pkt);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      got_q.delete();
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h42};
      send_pkt(pkt);
      wait_out(1, "midrst_echo");
      check("midrst_echo", 64'(take()), 64'h42);

      // ECHO with latency check
      acc_cyc.delete(); out_cyc.delete(); got_q.delete();
      pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h42, 8'h69, 8'h42, 8'h69};
      eb  = '{8'h42, 8'h69, 8'h42, 8'h69};
      send_pkt(pkt);
      wait_out(4, "echo8");
      for (int i = 0; i < 4; i++) begin
         check("echo8_lat", 64'(out_cyc[i]), 64'(acc_cyc[4 + i] + 1));
         check("echo8_data", 64'(take()), 64'(eb[i]));
      end

      // Reductions, 32-bit operands
      ops = '{32'hFFFF_FFFF, 32'h0000_0002};
      run_reduce(8'hAD, ops, 0, -1, 32'h0000_0001, "add_wrap");
      @(negedge clk);
      check("add_wrap_idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
      ops = '{32'h0F0F_0F0F, 32'hFFFF_0000};
      run_reduce(8'hE0, ops, 0, -1, 32'hF0F0_0F0F, "xor");
      ops = '{32'h0000_0005, 32'h8000_0000, 32'h7FFF_FFFF};
      run_reduce(8'hAA, ops, 0, -1, 32'h8000_0000, "max");
      ops.delete();
      run_reduce(8'hAD, ops, 0, -1, 32'h0000_0000, "add_len4");

      // ADD with 16-bit operands
      pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h34, 8'h12, 8'h01, 8'h00};
      foreach (pkt[i]) begin
         in_data2 = pkt[i]; in_valid2 = 1'b1;
         @(negedge clk);
         check("add16_in_ready", 64'(in_ready2), 64'd1);
         @(posedge clk); #1;
      end
      in_valid2 = 1'b0;
      t = 0;
      while (got2_q.size() < 2 && t < 100) begin @(posedge clk); #1; t++; end
      check("add16_count", 64'(got2_q.size()), 64'd2);
      if (got2_q.size() >= 2) begin
         check("add16_b0", 64'(got2_q[0]), 64'h35);
         check("add16_b1", 64'(got2_q[1]), 64'h12);
      end

      // Unknown opcode drains its payload silently
      got_q.delete();
      base = err_cnt;
      pkt = '{8'h11, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
      send_pkt(pkt);
      repeat (5) @(posedge clk);
      #1;
      check("unk_err_pulses", 64'(err_cnt - base), 64'd1);
      check("unk_no_output", 64'(got_q.size()), 64'd0);
      @(negedge clk);
      check("unk_idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
      ops = '{32'd1, 32'd2, 32'd3};
      run_reduce(8'hAD, ops, 0, -1, 32'd6, "add_after_unk");

      // ECHO under random back-pressure
      rand_ready = 1'b1;
      bp_mode    = 1'b1;
      base       = bp_viol;
      for (int p = 0; p < 3; p++) begin
         pkt = '{8'hEC, 8'h00, 8'h08, 8'h00};
         eb.delete();
         for (int i = 0; i < 4; i++) eb.push_back(8'($urandom_range(0, 255)));
         foreach (eb[i]) pkt.push_back(eb[i]);
         send_pkt(pkt);
         wait_out(4, "bp_echo");
         for (int i = 0; i < 4; i++) check("bp_echo_data", 64'(take()), 64'(eb[i]));
      end
      bp_mode = 1'b0;
      check("bp_ready_rule", 64'(bp_viol - base), 64'd0);

      // Random ADD packets against the reference sum
      for (int p = 0; p < 100; p++) begin
         ops.delete();
         if ($urandom_range(0, 9) == 0) begin
            run_reduce(8'hAD, ops, 0, int'($urandom_range(0, 3)), 32'd0, "rand_add_short");
         end else begin
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) ops.push_back($urandom);
            run_reduce(8'hAD, ops, int'($urandom_range(0, 3)), -1, ref_add(ops), "rand_add");
         end
      end
      rand_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
